colorbar_frame_writer: RTL and testbench
========================================

COLORBAR_FRAME_WRITER -- requirements
Module: colorbar_frame_writer

Interface
REQ-001 SHALL have parameter H_ACT, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_ACT, default 720, active lines per frame.
REQ-003 SHALL have parameter BURST_LEN, default 64, maximum 128-bit words per write request (1..65535).
REQ-004 SHALL have parameter BASE_ADDR, default 28'd0, DDR3 app address of the frame's first word.
REQ-005 SHALL have port clk, input, 1, sole clock (MIG ui_clk); all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; one clock, reset synchronous and active-low.
REQ-007 SHALL have port wr_req, output, 1, one-cycle burst request to the memory controller.
REQ-008 SHALL have port wr_req_addr, output, 28, app address of the burst's first word.
REQ-009 SHALL have port wr_length, output, 16, number of words in the requested burst.
REQ-010 SHALL have port wr_data, output, 128, current word offered to the controller.
REQ-011 SHALL have port wr_busy, input, 1, controller busy; no request while high.
REQ-012 SHALL have port wr_data_valid, input, 1, controller consumes wr_data this cycle.
REQ-013 SHALL have port wr_done, input, 1, one-cycle pulse: current burst fully written.
REQ-014 SHALL have port ui_wr_done, output, 1, level: whole frame written to DDR3.

Function
REQ-015 SHALL write exactly one frame of TOTAL = H_ACT*V_ACT/4 words, then stop; H_ACT*V_ACT SHALL be a multiple of 4.
REQ-016 SHALL pack 4 pixels per word, pixel n of the word in bits [32n+31:32n], each as {8'h00, R, G, B}.
REQ-017 SHALL colour pixel at column x (0..H_ACT-1) from 8 equal vertical bars, bar index = x / (H_ACT/8): white 0xFFFFFF, yellow 0xFFFF00, cyan 0x00FFFF, green 0x00FF00, magenta 0xFF00FF, red 0xFF0000, blue 0x0000FF, black 0x000000; index >7 clamps to black.
REQ-018 SHALL keep column counter x wrapping H_ACT-1 -> 0 and line counter advancing per wrap; colour independent of line.
REQ-019 SHALL implement states IDLE, REQ, DATA, WAIT_DONE, FINISH.
REQ-020 IDLE: one cycle after reset release, go to REQ.
REQ-021 REQ: when wr_busy low, drive wr_req high for exactly one cycle with wr_req_addr and wr_length valid that same cycle, go to DATA; while wr_busy high, hold wr_req low.
REQ-022 wr_length SHALL equal min(BURST_LEN, words remaining); final burst may be short.
REQ-023 wr_req_addr SHALL start at BASE_ADDR and advance by wr_length*8 after each completed burst (16-bit DDR3, 8 addresses per 128-bit word), modulo 2^28.
REQ-024 DATA: wr_data SHALL hold the current word stable; on each cycle with wr_data_valid high, the word is consumed and the next word appears the following cycle; after wr_length consumptions go to WAIT_DONE.
REQ-025 wr_data_valid in REQ, WAIT_DONE, IDLE or FINISH SHALL be ignored (no advance).
REQ-026 WAIT_DONE: on wr_done go to REQ if words remain, else FINISH; wr_done in any other state ignored.
REQ-027 wr_done coincident with the last wr_data_valid of a burst SHALL be honoured (transition straight to REQ/FINISH).
REQ-028 FINISH: ui_wr_done high, wr_req low, all inputs ignored until reset.
REQ-029 wr_data SHALL be valid (first word of the burst) no later than the cycle wr_req is asserted.

Reset
REQ-030 With rst_n low at a clock edge: state IDLE, wr_req 0, wr_req_addr BASE_ADDR, wr_length 0, wr_data 0, ui_wr_done 0, all counters 0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst; after release the frame restarts from word 0 at BASE_ADDR.

Verification
REQ-032 H_ACT=16,V_ACT=2,BURST_LEN=4, wr_busy 0, wr_data_valid always 1, wr_done 1 cycle after 4th word -> two requests, addr 0 then 32, length 4 each; word0 = 128'h00FFFF00_00FFFF00_00FFFFFF_00FFFFFF; ui_wr_done rises after 2nd wr_done.
REQ-033 H_ACT=16,V_ACT=3,BURST_LEN=5 -> lengths 5,5,2 at addrs 0,40,80; exactly 12 words consumed; ui_wr_done only after third wr_done.
REQ-034 wr_busy held high 20 cycles in REQ -> wr_req stays 0; wr_req pulses exactly 1 cycle after wr_busy falls.
REQ-035 Random gaps on wr_data_valid plus spurious wr_done during DATA -> wr_data stable across gaps, words in sequence, spurious wr_done ignored.
REQ-036 rst_n low 1 cycle during second burst -> outputs to reset values; restart issues addr BASE_ADDR, word0 pattern again.

Source files
------------

// File: rtl/colorbar_frame_writer.sv
// rtl/colorbar_frame_writer.sv - writes one 8-bar colour test frame to DDR3 as 128-bit bursts
// Four 32-bit {00,R,G,B} pixels per word; bursts of up to BURST_LEN words.
module colorbar_frame_writer #(
  parameter int          H_ACT     = 1280,
  parameter int          V_ACT     = 720,
  parameter int          BURST_LEN = 64,
  parameter logic [27:0] BASE_ADDR = 28'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         wr_req,
  output logic [27:0]  wr_req_addr,
  output logic [15:0]  wr_length,
  output logic [127:0] wr_data,
  input  logic         wr_busy,
  input  logic         wr_data_valid,
  input  logic         wr_done,
  output logic         ui_wr_done
);

  localparam int TOTAL = H_ACT * V_ACT / 4;
  localparam int BAR_W = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;

  typedef enum logic [2:0] {IDLE, REQ, DATA, WAIT_DONE, FINISH} state_t;

  state_t      state;
  logic [15:0] x;
  logic [15:0] line;
  logic [15:0] burst_cnt;
  logic [31:0] words_sent;

  logic        consume;
  logic        last_word;
  logic        burst_end;
  logic [31:0] sent_next;
  logic        col_wrap;
  logic [15:0] x_next;
  int          xs;

  function automatic logic [23:0] bar_color(input int bar);
    case (bar)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // A word may straddle the end of a line when H_ACT is not a multiple of 4.
  function automatic logic [127:0] word_at(input logic [15:0] col0);
    logic [127:0] w;
    int c;
    w = '0;
    for (int n = 0; n < 4; n++) begin
      c = int'(col0) + n;
      if (c >= H_ACT) c = c - H_ACT;
      w[32*n +: 32] = {8'h00, bar_color(c / BAR_W)};
    end
    return w;
  endfunction

  function automatic logic [15:0] burst_len_for(input logic [31:0] sent);
    int rem;
    rem = TOTAL - int'(sent);
    return (rem < BURST_LEN) ? 16'(rem) : 16'(BURST_LEN);
  endfunction

  always_comb begin
    consume   = (state == DATA) && wr_data_valid;
    last_word = (burst_cnt + 16'd1) == wr_length;
    burst_end = (consume && last_word && wr_done) || (state == WAIT_DONE && wr_done);
    sent_next = words_sent + {31'd0, consume};
    xs        = int'(x) + 4;
    col_wrap  = xs >= H_ACT;
    x_next    = col_wrap ? 16'(xs - H_ACT) : 16'(xs);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_req      <= 1'b0;
      wr_req_addr <= BASE_ADDR;
      wr_length   <= '0;
      wr_data     <= '0;
      ui_wr_done  <= 1'b0;
      x           <= '0;
      line        <= '0;
      burst_cnt   <= '0;
      words_sent  <= '0;
    end else begin
      wr_req <= 1'b0;
      case (state)
        IDLE: begin
          wr_data   <= word_at(x);
          wr_length <= burst_len_for(words_sent);
          state     <= REQ;
        end
        REQ: begin
          if (!wr_busy) begin
            wr_req <= 1'b1;
            state  <= DATA;
          end
        end
        DATA: begin
          if (consume) begin
            words_sent <= sent_next;
            x          <= x_next;
            wr_data    <= word_at(x_next);
            if (col_wrap) line <= (line == 16'(V_ACT - 1)) ? '0 : line + 16'd1;
            if (last_word) begin
              burst_cnt <= '0;
              state     <= WAIT_DONE;
            end else begin
              burst_cnt <= burst_cnt + 16'd1;
            end
          end
        end
        WAIT_DONE: ;
        FINISH: ;
        default: state <= IDLE;
      endcase

      // Completion may arrive together with the last data beat; it overrides WAIT_DONE.
      if (burst_end) begin
        wr_req_addr <= wr_req_addr + {9'd0, wr_length, 3'b000};
        burst_cnt   <= '0;
        if (sent_next == 32'(TOTAL)) begin
          state      <= FINISH;
          ui_wr_done <= 1'b1;
        end else begin
          wr_length <= burst_len_for(sent_next);
          state     <= REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_colorbar_frame_writer.sv
// tb/tb_colorbar_frame_writer.sv - directed + randomized check of colorbar_frame_writer
// Reference words and burst plan come from pixel/bar arithmetic, not from the RTL.
module tb_colorbar_frame_writer;

  localparam int          H     = 16;
  localparam int          V     = 3;
  localparam int          BL    = 5;
  localparam logic [27:0] BASE  = 28'd0;
  localparam int          TOTAL = H * V / 4;
  localparam logic [23:0] PAL [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_busy = 1'b0;
  logic         wr_data_valid = 1'b0;
  logic         wr_done = 1'b0;
  logic         wr_req;
  logic [27:0]  wr_req_addr;
  logic [15:0]  wr_length;
  logic [127:0] wr_data;
  logic         ui_wr_done;

  int n_checks = 0;
  int n_fail   = 0;

  colorbar_frame_writer #(
    .H_ACT(H), .V_ACT(V), .BURST_LEN(BL), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_req_addr(wr_req_addr),
    .wr_length(wr_length), .wr_data(wr_data), .wr_busy(wr_busy),
    .wr_data_valid(wr_data_valid), .wr_done(wr_done), .ui_wr_done(ui_wr_done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] exp_word(input int k);
    logic [127:0] w;
    int p, col, bar;
    w = '0;
    for (int n = 0; n < 4; n++) begin
      p   = 4 * k + n;
      col = p % H;
      bar = col / (H / 8);
      if (bar > 7) bar = 7;
      w[32*n +: 32] = {8'h00, PAL[bar]};
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wr_req"}, wr_req, 1'b0);
    chk({tag, "_addr"}, wr_req_addr, BASE);
    chk({tag, "_len"}, wr_length, 16'd0);
    chk({tag, "_data"}, wr_data, 128'd0);
    chk({tag, "_ui"}, ui_wr_done, 1'b0);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wr_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) chk("req_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_burst(input int start, input int len, input bit rnd, input bit spur,
                           input bit coinc, input int abort_at, output bit aborted);
    bit ok, v, last;
    int consumed, guard, gaps;
    aborted = 1'b0;
    wait_req(ok);
    if (!ok) return;
    chk("req_addr", wr_req_addr, BASE + 28'(start * 8));
    chk("req_len", wr_length, 16'(len));
    chk("first_word", wr_data, exp_word(start));
    if (start == 0) chk("word0_literal", wr_data, 128'h00FFFF00_00FFFF00_00FFFFFF_00FFFFFF);
    consumed = 0;
    guard = 0;
    while (consumed < len && guard < 300) begin
      guard++;
      if (consumed == abort_at) begin
        rst_n = 1'b0;
        wr_data_valid = 1'b1;
        wr_done = 1'b0;
        step();
        check_reset("mid_rst");
        rst_n = 1'b1;
        aborted = 1'b1;
        return;
      end
      chk("data_word", wr_data, exp_word(start + consumed));
      v    = rnd ? ($urandom_range(2) != 0) : 1'b1;
      last = v && (consumed + 1 == len);
      wr_data_valid = v;
      wr_done = last ? coinc : (spur && $urandom_range(3) == 0);
      step();
      chk("req_pulse", wr_req, 1'b0);
      if (v) consumed++;
    end
    if (guard >= 300) chk("burst_timeout", 1'b0, 1'b1);
    wr_done = 1'b0;
    if (!coinc) begin
      gaps = rnd ? $urandom_range(2) : 0;
      for (int g = 0; g < gaps; g++) begin
        wr_data_valid = rnd ? 1'($urandom_range(1)) : 1'b1;
        step();
        chk("wait_ui", ui_wr_done, 1'b0);
      end
      if (start + len < TOTAL) chk("hold_wait", wr_data, exp_word(start + len));
      wr_data_valid = rnd ? 1'($urandom_range(1)) : 1'b1;
      wr_done = 1'b1;
      step();
      wr_done = 1'b0;
    end
    chk("ui_after_done", ui_wr_done, (start + len == TOTAL));
  endtask

  task automatic run_frame(input bit rnd, input bit spur, input int coinc_mode,
                           input int abort_burst, input int abort_at, input int busy_burst);
    int start, len, b;
    bit aborted, coinc;
    start = 0;
    b = 0;
    while (start < TOTAL) begin
      len = (TOTAL - start < BL) ? TOTAL - start : BL;
      if (b == busy_burst) begin
        wr_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
          step();
          chk("busy_no_req", wr_req, 1'b0);
        end
        wr_busy = 1'b0;
        step();
        chk("req_after_busy", wr_req, 1'b1);
      end
      coinc = (coinc_mode == 1) ? (start + len == TOTAL)
            : (coinc_mode == 2) ? 1'($urandom_range(1)) : 1'b0;
      run_burst(start, len, rnd, spur, coinc, (b == abort_burst) ? abort_at : -1, aborted);
      if (aborted) return;
      start += len;
      b++;
    end
  endtask

  task automatic finish_idle();
    for (int i = 0; i < 10; i++) begin
      wr_busy       = 1'($urandom_range(1));
      wr_data_valid = 1'($urandom_range(1));
      wr_done       = 1'($urandom_range(1));
      step();
      chk("fin_no_req", wr_req, 1'b0);
      chk("fin_ui", ui_wr_done, 1'b1);
    end
    wr_busy = 1'b0;
    wr_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_data_valid = 1'b1;
    step();
    step();
    check_reset("rst");
    rst_n = 1'b1;
    step();
    chk("idle_no_req", wr_req, 1'b0);

    // Frame 1: valid always high, busy hold on burst 1, done coincident on last beat.
    run_frame(1'b0, 1'b0, 1, -1, -1, 1);
    finish_idle();

    rst_n = 1'b0;
    step();
    check_reset("rst2");
    rst_n = 1'b1;

    // Frame 2: random gaps and spurious done, reset in the middle of burst 1.
    run_frame(1'b1, 1'b1, 2, 1, 2, -1);
    // Frame 3: restart from word 0, runs to completion.
    run_frame(1'b1, 1'b1, 2, -1, -1, -1);
    finish_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
